vrf_writeback: RTL and testbench
================================

Name: vrf_writeback

Overview:
- Write-back stage directly downstream of the vector ALU.
- Captures each ALU result with its destination register and PPPWW field, builds a participation mask, and commits a masked merge into a 32 x 64-bit vector register file.
- Serves two combinational read ports to the decode stage and flags read-after-write hazards to decode.
- Bit numbering is big-endian throughout: bit 0 is the MSB.

Parameters:
- NREG, 32, number of vector registers (address width 5)
- DW, 64, register width in bits

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- ALU_wr_en  in  1  ALU result valid this cycle
- ALU_rD  in  5  destination register
- ALU_PPPWW  in  5  [0:2] PPP participation, [3:4] WW width (00=8b, 01=16b, 10=32b, 11=64b)
- ALU_output  in  64  result data
- ID_rA_addr  in  5  read port A address
- ID_rB_addr  in  5  read port B address
- ID_rA_used  in  1  port A read is live (used for hazard detection)
- ID_rB_used  in  1  port B read is live
- ID_rA_data  out  64  read port A data (combinational)
- ID_rB_data  out  64  read port B data (combinational)
- WB_hazard  out  1  decode must stall (combinational)
- WB_commit_cnt  out  16  number of committed non-empty writes, saturates at 0xFFFF

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset:
  - All register-file entries cleared to 0.
  - W1_valid cleared to 0, so a pending write is discarded and never committed.
  - WB_commit_cnt cleared to 0.
  - Read data outputs follow the cleared file combinationally.
- Mask generation (combinational from PPPWW):
  - Subfield k occupies bits [k*W : k*W+W-1].
  - PPP=000: all bits.
  - PPP=001: bits [0:31].
  - PPP=010: bits [32:63].
  - PPP=011: even subfields (k=0,2,...).
  - PPP=100: odd subfields.
  - PPP=101..111: mask 0, reserved.
  - WW=11 with PPP=011 gives the full word; WW=11 with PPP=100 gives mask 0.
- Stage W1 (posedge, reset=0):
  - If ALU_wr_en=1: W1_rD, W1_data and W1_mask are loaded, and W1_valid=1.
  - Otherwise W1_valid=0.
- Commit (same posedge, using old W1 contents):
  - If W1_valid=1: rf[W1_rD] <= (rf[W1_rD] & ~W1_mask) | (W1_data & W1_mask).
  - If additionally W1_mask != 0, WB_commit_cnt increments, holding at 0xFFFF.
- Latency: a result presented at edge N is visible in the register file after edge N+1.
- Simultaneous events:
  - A new ALU result entering W1 and the previous result committing on the same edge is normal pipelined operation.
  - Back-to-back writes to the same rD merge in order; the second merge sees the first's committed value.
- Reads: ID_rX_data = rf[ID_rX_addr], except where bypass applies (see Optional Feature).
- Hazard, evaluated per live port:
  - Match against ALU_rD when ALU_wr_en=1: always a hazard.
  - Match against W1_rD when W1_valid=1: a hazard only when bypass is compiled out.
  - Unused ports never raise a hazard.
  - The block itself never stalls; decode holds its instruction, and the ALU must drop ALU_wr_en during the stall.

Optional Feature:
- Macro: WB_BYPASS_EN
- Defined:
  - When W1_valid=1 and ID_rX_addr==W1_rD, the read port returns the merged value (rf & ~W1_mask) | (W1_data & W1_mask).
  - W1 matches do not raise WB_hazard.
- Undefined:
  - No bypass path; reads always return rf contents.
  - W1 matches raise WB_hazard.

Test Plan:
- Reset mid-write: ALU_wr_en=1, rD=3, data=0xFFFF_FFFF_FFFF_FFFF, then reset on the next edge -> rf[3]=0, WB_commit_cnt=0.
- Full write then reads:
  - rD=5, PPPWW=000_11, data=0x0123_4567_89AB_CDEF -> after 2 edges ID_rA_data (addr 5)=0x0123_4567_89AB_CDEF, WB_commit_cnt=1.
- Partial merge:
  - rf[5]=0x0123_4567_89AB_CDEF.
  - Write rD=5, PPPWW=011_00 (even bytes), data=0xFFFF_FFFF_FFFF_FFFF -> rf[5]=0xFF23_FF67_FFAB_FFEF.
  - Then PPPWW=010_10, data=0 -> rf[5]=0xFF23_FF67_0000_0000.
- Reserved and empty masks:
  - PPP=101, or PPPWW=100_11 -> rf unchanged, WB_commit_cnt unchanged.
- Hazard and bypass:
  - Write rD=7 with data 0xAA..AA while ID_rA_addr=7, ID_rA_used=1 -> WB_hazard=1 in the ALU cycle.
  - In the W1 cycle: WB_BYPASS_EN defined -> WB_hazard=0, ID_rA_data=0xAAAA_AAAA_AAAA_AAAA. Undefined -> WB_hazard=1.
  - Same addresses with ID_rA_used=0 -> WB_hazard=0.
- Back-to-back and saturation:
  - Writes to rD=9 with PPP=001 data 0x1111.. then PPP=010 data 0x2222.. on consecutive cycles -> rf[9]=0x1111_1111_2222_2222.
  - Force 65,540 non-empty commits -> WB_commit_cnt=0xFFFF.

Source files
------------

// File: rtl/vrf_writeback.sv
`default_nettype none
// vrf_writeback: ALU write-back stage. Each result is merged under a PPPWW mask into a 32 x 64-bit register file.
// Optional macro WB_BYPASS_EN forwards the pending W1 merge to the read ports. Rev 1.0
module vrf_writeback #(
  parameter int NREG = 32,
  parameter int DW   = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ALU_wr_en,
  input  logic [$clog2(NREG)-1:0]  ALU_rD,
  input  logic [4:0]               ALU_PPPWW,
  input  logic [DW-1:0]            ALU_output,
  input  logic [$clog2(NREG)-1:0]  ID_rA_addr,
  input  logic [$clog2(NREG)-1:0]  ID_rB_addr,
  input  logic                     ID_rA_used,
  input  logic                     ID_rB_used,
  output logic [DW-1:0]            ID_rA_data,
  output logic [DW-1:0]            ID_rB_data,
  output logic                     WB_hazard,
  output logic [15:0]              WB_commit_cnt
);

  localparam int AW = $clog2(NREG);

  logic [2:0]    w_ppp;
  logic [1:0]    w_ww;
  logic [DW-1:0] w_mask;
  logic [DW-1:0] w_merge;
  logic          w_a_alu;
  logic          w_b_alu;
  logic          w_a_w1;
  logic          w_b_w1;

  logic          r_w1_valid;
  logic [AW-1:0] r_w1_rd;
  logic [DW-1:0] r_w1_data;
  logic [DW-1:0] r_w1_mask;
  logic [DW-1:0] r_rf [NREG];
  logic [15:0]   r_cnt;

  assign w_ppp = ALU_PPPWW[4:2];
  assign w_ww  = ALU_PPPWW[1:0];

  // b is the big-endian bit index (0 = MSB); its subfield number is b / (8 << WW).
  always_comb begin
    w_mask = '0;
    for (int b = 0; b < DW; b++) begin
      case (w_ppp)
        3'd0:    w_mask[DW-1-b] = 1'b1;
        3'd1:    w_mask[DW-1-b] = (b < DW/2);
        3'd2:    w_mask[DW-1-b] = (b >= DW/2);
        3'd3:    w_mask[DW-1-b] = (((b >> (3 + int'(w_ww))) % 2) == 0);
        3'd4:    w_mask[DW-1-b] = (((b >> (3 + int'(w_ww))) % 2) == 1);
        default: w_mask[DW-1-b] = 1'b0;
      endcase
    end
  end

  assign w_merge = (r_rf[r_w1_rd] & ~r_w1_mask) | (r_w1_data & r_w1_mask);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_w1_valid <= 1'b0;
      r_w1_rd    <= '0;
      r_w1_data  <= '0;
      r_w1_mask  <= '0;
      r_cnt      <= '0;
      for (int i = 0; i < NREG; i++) begin
        r_rf[i] <= '0;
      end
    end else begin
      r_w1_valid <= ALU_wr_en;
      if (ALU_wr_en) begin
        r_w1_rd   <= ALU_rD;
        r_w1_data <= ALU_output;
        r_w1_mask <= w_mask;
      end
      if (r_w1_valid) begin
        r_rf[r_w1_rd] <= w_merge;
        if ((|r_w1_mask) && (r_cnt != 16'hFFFF)) begin
          r_cnt <= r_cnt + 16'd1;
        end
      end
    end
  end

  assign w_a_alu = ID_rA_used && ALU_wr_en && (ID_rA_addr == ALU_rD);
  assign w_b_alu = ID_rB_used && ALU_wr_en && (ID_rB_addr == ALU_rD);
  assign w_a_w1  = r_w1_valid && (ID_rA_addr == r_w1_rd);
  assign w_b_w1  = r_w1_valid && (ID_rB_addr == r_w1_rd);

`ifdef WB_BYPASS_EN
  assign ID_rA_data = w_a_w1 ? w_merge : r_rf[ID_rA_addr];
  assign ID_rB_data = w_b_w1 ? w_merge : r_rf[ID_rB_addr];
  assign WB_hazard  = w_a_alu || w_b_alu;
`else
  assign ID_rA_data = r_rf[ID_rA_addr];
  assign ID_rB_data = r_rf[ID_rB_addr];
  assign WB_hazard  = w_a_alu || w_b_alu || (ID_rA_used && w_a_w1) || (ID_rB_used && w_b_w1);
`endif

  assign WB_commit_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vrf_writeback.sv
`default_nettype none
// tb_vrf_writeback: directed vector table, hand sequences and randomized run against a behavioural model.
module tb_vrf_writeback;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        ALU_wr_en;
  logic [4:0]  ALU_rD;
  logic [4:0]  ALU_PPPWW;
  logic [63:0] ALU_output;
  logic [4:0]  ID_rA_addr;
  logic [4:0]  ID_rB_addr;
  logic        ID_rA_used;
  logic        ID_rB_used;
  logic [63:0] ID_rA_data;
  logic [63:0] ID_rB_data;
  logic        WB_hazard;
  logic [15:0] WB_commit_cnt;

  int n_cmp;
  int n_bad;

  vrf_writeback #(.NREG(32), .DW(64)) dut (
    .clk           (clk),
    .reset         (reset),
    .ALU_wr_en     (ALU_wr_en),
    .ALU_rD        (ALU_rD),
    .ALU_PPPWW     (ALU_PPPWW),
    .ALU_output    (ALU_output),
    .ID_rA_addr    (ID_rA_addr),
    .ID_rB_addr    (ID_rB_addr),
    .ID_rA_used    (ID_rA_used),
    .ID_rB_used    (ID_rB_used),
    .ID_rA_data    (ID_rA_data),
    .ID_rB_data    (ID_rB_data),
    .WB_hazard     (WB_hazard),
    .WB_commit_cnt (WB_commit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [4:0]  rd;
    logic [4:0]  pppww;
    logic [63:0] data;
    logic [4:0]  ra;
    logic        ua;
    logic [4:0]  rb;
    logic        ub;
    logic [63:0] exp_a;
    logic [63:0] exp_b;
    logic        exp_haz;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl [16];

  // Behavioural reference: register array plus one pending write.
  logic [63:0] m_rf [32];
  logic        m_pv;
  logic [4:0]  m_prd;
  logic [63:0] m_pd;
  logic [63:0] m_pm;
  int          m_cnt;

  function automatic vec_t mk(input logic wr, input logic [4:0] rd, input logic [4:0] f,
                              input logic [63:0] d, input logic [4:0] ra, input logic ua,
                              input logic [4:0] rb, input logic ub, input logic [63:0] ea,
                              input logic [63:0] eb, input logic eh, input logic [15:0] ec);
    vec_t v;
    v.wr = wr; v.rd = rd; v.pppww = f; v.data = d;
    v.ra = ra; v.ua = ua; v.rb = rb; v.ub = ub;
    v.exp_a = ea; v.exp_b = eb; v.exp_haz = eh; v.exp_cnt = ec;
    return v;
  endfunction

  function automatic logic [63:0] ref_mask(input logic [4:0] f);
    logic [63:0] m;
    int w;
    int ppp;
    m   = '0;
    w   = 8 << f[1:0];
    ppp = int'(f[4:2]);
    for (int b = 0; b < 64; b++) begin
      int k;
      bit on;
      k = b / w;
      case (ppp)
        0:       on = 1'b1;
        1:       on = (b < 32);
        2:       on = (b >= 32);
        3:       on = ((k % 2) == 0);
        4:       on = ((k % 2) == 1);
        default: on = 1'b0;
      endcase
      m[63-b] = on;
    end
    return m;
  endfunction

  function automatic logic [63:0] ref_read(input logic [4:0] a);
    if (BYP && m_pv && (a == m_prd))
      return (m_rf[a] & ~m_pm) | (m_pd & m_pm);
    return m_rf[a];
  endfunction

  function automatic logic ref_port_haz(input logic [4:0] a, input logic u);
    if (!u) return 1'b0;
    if (ALU_wr_en && (a == ALU_rD)) return 1'b1;
    if (!BYP && m_pv && (a == m_prd)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_pv = 1'b0; m_prd = '0; m_pd = '0; m_pm = '0; m_cnt = 0;
  endtask

  task automatic model_tick();
    if (m_pv) begin
      m_rf[m_prd] = (m_rf[m_prd] & ~m_pm) | (m_pd & m_pm);
      if ((m_pm != 0) && (m_cnt < 65535)) m_cnt = m_cnt + 1;
    end
    m_pv = ALU_wr_en;
    if (ALU_wr_en) begin
      m_prd = ALU_rD; m_pd = ALU_output; m_pm = ref_mask(ALU_PPPWW);
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic [4:0] rd, input logic [4:0] f, input logic [63:0] d,
                       input logic [4:0] ra, input logic ua, input logic [4:0] rb, input logic ub);
    ALU_wr_en = wr; ALU_rD = rd; ALU_PPPWW = f; ALU_output = d;
    ID_rA_addr = ra; ID_rA_used = ua; ID_rB_addr = rb; ID_rB_used = ub;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 64'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    edge_step();
    edge_step();
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    model_reset();
    do_reset();
    #1;
    chk("reset_rA", ID_rA_data, 64'd0);
    chk("reset_rB", ID_rB_data, 64'd0);
    chk("reset_haz", {63'd0, WB_hazard}, 64'd0);
    chk("reset_cnt", {48'd0, WB_commit_cnt}, 64'd0);

    // Reset arriving while a write sits in W1 discards it.
    drive(1'b1, 5'd3, 5'b000_11, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3, 1'b0, 5'd0, 1'b0);
    edge_step();
    reset = 1'b1;
    ALU_wr_en = 1'b0;
    edge_step();
    reset = 1'b0;
    #1;
    chk("rstmid_rf3", ID_rA_data, 64'd0);
    chk("rstmid_cnt", {48'd0, WB_commit_cnt}, 64'd0);
    edge_step();
    chk("rstmid_rf3_later", ID_rA_data, 64'd0);
    chk("rstmid_cnt_later", {48'd0, WB_commit_cnt}, 64'd0);

    tbl[0]  = mk(1, 5, 5'b000_11, 64'h0123_4567_89AB_CDEF, 5, 0, 0, 0, 64'd0, 64'd0, 0, 16'd0);
    tbl[1]  = mk(0, 0, 5'b000_00, 64'd0, 1, 0, 0, 0, 64'd0, 64'd0, 0, 16'd0);
    tbl[2]  = mk(0, 0, 5'b000_00, 64'd0, 5, 0, 0, 0, 64'h0123_4567_89AB_CDEF, 64'd0, 0, 16'd1);
    tbl[3]  = mk(1, 5, 5'b011_00, 64'hFFFF_FFFF_FFFF_FFFF, 5, 0, 0, 0, 64'h0123_4567_89AB_CDEF, 64'd0, 0, 16'd1);
    tbl[4]  = mk(1, 5, 5'b010_10, 64'd0, 6, 0, 0, 0, 64'd0, 64'd0, 0, 16'd1);
    tbl[5]  = mk(0, 0, 5'b000_00, 64'd0, 6, 0, 0, 0, 64'd0, 64'd0, 0, 16'd2);
    tbl[6]  = mk(0, 0, 5'b000_00, 64'd0, 5, 0, 0, 0, 64'hFF23_FF67_0000_0000, 64'd0, 0, 16'd3);
    tbl[7]  = mk(1, 5, 5'b101_00, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0, 0, 0, 64'd0, 64'd0, 0, 16'd3);
    tbl[8]  = mk(1, 5, 5'b100_11, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0, 0, 0, 64'd0, 64'd0, 0, 16'd3);
    tbl[9]  = mk(0, 0, 5'b000_00, 64'd0, 2, 0, 0, 0, 64'd0, 64'd0, 0, 16'd3);
    tbl[10] = mk(0, 0, 5'b000_00, 64'd0, 5, 0, 0, 0, 64'hFF23_FF67_0000_0000, 64'd0, 0, 16'd3);
    tbl[11] = mk(1, 9, 5'b001_00, 64'h1111_1111_1111_1111, 5, 1, 0, 0, 64'hFF23_FF67_0000_0000, 64'd0, 0, 16'd3);
    tbl[12] = mk(1, 9, 5'b010_00, 64'h2222_2222_2222_2222, 3, 0, 0, 0, 64'd0, 64'd0, 0, 16'd3);
    tbl[13] = mk(0, 0, 5'b000_00, 64'd0, 3, 0, 0, 0, 64'd0, 64'd0, 0, 16'd4);
    tbl[14] = mk(0, 0, 5'b000_00, 64'd0, 9, 0, 5, 1, 64'h1111_1111_2222_2222, 64'hFF23_FF67_0000_0000, 0, 16'd5);
    tbl[15] = mk(1, 7, 5'b000_11, 64'hAAAA_AAAA_AAAA_AAAA, 7, 1, 7, 0, 64'd0, 64'd0, 1, 16'd5);

    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].wr, tbl[i].rd, tbl[i].pppww, tbl[i].data,
            tbl[i].ra, tbl[i].ua, tbl[i].rb, tbl[i].ub);
      #1;
      chk($sformatf("tbl%0d_rA", i), ID_rA_data, tbl[i].exp_a);
      chk($sformatf("tbl%0d_rB", i), ID_rB_data, tbl[i].exp_b);
      chk($sformatf("tbl%0d_haz", i), {63'd0, WB_hazard}, {63'd0, tbl[i].exp_haz});
      chk($sformatf("tbl%0d_cnt", i), {48'd0, WB_commit_cnt}, {48'd0, tbl[i].exp_cnt});
      edge_step();
    end

    // rD=7 write now sits in W1: bypass or stall depending on build.
    drive(1'b0, 5'd0, 5'd0, 64'd0, 5'd7, 1'b1, 5'd0, 1'b0);
    #1;
    chk("w1_haz", {63'd0, WB_hazard}, {63'd0, !BYP});
    chk("w1_rA", ID_rA_data, BYP ? 64'hAAAA_AAAA_AAAA_AAAA : 64'd0);
    ID_rA_used = 1'b0;
    #1;
    chk("w1_unused_haz", {63'd0, WB_hazard}, 64'd0);
    edge_step();
    ID_rA_used = 1'b1;
    #1;
    chk("after_rA", ID_rA_data, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("after_haz", {63'd0, WB_hazard}, 64'd0);
    chk("after_cnt", {48'd0, WB_commit_cnt}, 64'd6);

    do_reset();
    for (int c = 0; c < 600; c++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom),
            {$urandom, $urandom}, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      #1;
      chk("rnd_rA", ID_rA_data, ref_read(ID_rA_addr));
      chk("rnd_rB", ID_rB_data, ref_read(ID_rB_addr));
      chk("rnd_haz", {63'd0, WB_hazard},
          {63'd0, ref_port_haz(ID_rA_addr, ID_rA_used) | ref_port_haz(ID_rB_addr, ID_rB_used)});
      chk("rnd_cnt", {48'd0, WB_commit_cnt}, 64'(m_cnt));
      model_tick();
      edge_step();
    end

    for (int c = 0; c < 65540; c++) begin
      drive(1'b1, 5'($urandom_range(0, 31)), 5'b000_11, {$urandom, $urandom}, 5'd0, 1'b0, 5'd0, 1'b0);
      model_tick();
      edge_step();
    end
    drive(1'b0, 5'd0, 5'd0, 64'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    model_tick();
    edge_step();
    model_tick();
    edge_step();
    chk("sat_cnt", {48'd0, WB_commit_cnt}, 64'h0000_0000_0000_FFFF);
    chk("sat_model_cnt", {48'd0, WB_commit_cnt}, 64'(m_cnt));
    for (int r = 0; r < 32; r += 5) begin
      ID_rA_addr = 5'(r);
      #1;
      chk($sformatf("sat_rf%0d", r), ID_rA_data, ref_read(5'(r)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
